// File: rtl/fillq_sched_pkg.sv
// Fill queue scheduler shared definitions and round-robin helper.
// Packages: mem_defs (types/sizes), gen_funcs (rr find-first).
package mem_defs;
  localparam int FLQ_NUM_ENTRIES = 4;
  localparam int FLQ_MEM_CREDITS = 2;
  localparam int FLQ_LINE_OFFSET = 6;
  localparam int FLQ_PADDR_W     = 40;

  typedef logic [$clog2(FLQ_NUM_ENTRIES)-1:0] t_flq_id;
  typedef logic [FLQ_PADDR_W-1:0]             t_paddr;
endpackage

package gen_funcs;
  // Index of first set bit at or after ptr, wrapping at n; -1 if none.
  function automatic int rr_find(
    input logic [31:0] req,
    input int          n,
    input int          ptr
  );
    int idx;
    int res;
    res = -1;
    for (int k = 0; k < 32; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (res < 0 && req[idx[4:0]]) res = idx;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/fillq_sched_arb.sv
// Round-robin arbiter with registered pointer and optional winner hold.
// HOLD keeps an ungranted winner stable while it still requests.
module flq_rr_arb
  import gen_funcs::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 0,
  localparam int IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_id,
  output logic          any
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          hold_q, hold_d;
  logic [IW-1:0] hold_id_q, hold_id_d;
  logic [31:0]   req32;
  logic [IW-1:0] pick_id;
  int            r;

  always_comb begin
    req32          = '0;
    req32[N-1:0]   = req;
    r              = rr_find(req32, N, int'(ptr_q));
    any            = |req;
    pick_id        = any ? IW'(r) : '0;
    win_id         = pick_id;
    if (HOLD != 0 && hold_q && req[hold_id_q]) win_id = hold_id_q;
    win_oh         = any ? ({{(N-1){1'b0}}, 1'b1} << win_id) : '0;
  end

  always_comb begin
    ptr_d     = ptr_q;
    hold_d    = 1'b0;
    hold_id_d = hold_id_q;
    if (adv && any) begin
      ptr_d = (win_id == IW'(N-1)) ? '0 : win_id + 1'b1;
    end else if (any && HOLD != 0) begin
      hold_d    = 1'b1;
      hold_id_d = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
    end
  end

endmodule

// File: rtl/fillq_sched.sv
// Fill queue control: allocation/merge, memory credit arbitration, pipe RR.
// Optional perf counters enabled by FLQ_SCHED_PERF_EN.
module fillq_sched
  import mem_defs::*;
#(
  parameter int NUM_ENTRIES = FLQ_NUM_ENTRIES,
  parameter int MEM_CREDITS = FLQ_MEM_CREDITS,
  parameter int LINE_OFFSET = FLQ_LINE_OFFSET,
  localparam int IDW        = $clog2(NUM_ENTRIES),
  localparam int PA         = FLQ_PADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_req_mm5,
  input  t_paddr                       alloc_paddr_mm5,
  output logic                         alloc_gnt_mm5,
  output logic [NUM_ENTRIES-1:0]       alloc_vec_mm5,
  output logic                         alloc_merge_mm5,
  output logic                         alloc_nack_mm5,
  output logic                         full,
  input  logic [NUM_ENTRIES-1:0]       e_valid,
  input  t_paddr [NUM_ENTRIES-1:0]     e_paddr,
  input  logic [NUM_ENTRIES-1:0]       e_mem_req,
  output logic [NUM_ENTRIES-1:0]       e_mem_gnt,
  input  logic                         mem_rdy,
  input  logic                         mem_rsp_valid,
  input  logic [NUM_ENTRIES-1:0]       e_pipe_req_mm0,
  output logic [NUM_ENTRIES-1:0]       e_pipe_gnt_mm0,
  output logic                         pipe_req_mm0,
  output logic [IDW-1:0]               pipe_sel_id_mm0,
  input  logic                         pipe_gnt_mm0
`ifdef FLQ_SCHED_PERF_EN
  ,
  output logic [3:0][31:0]             perf_cnt
`endif
);

  localparam int CW = $clog2(MEM_CREDITS + 1);

  logic [NUM_ENTRIES-1:0] pend_q, pend_d;
  logic [NUM_ENTRIES-1:0] match, occ, free_oh;
  logic                   free_found;
  logic [CW-1:0]          credits_q, credits_d;

  logic [NUM_ENTRIES-1:0] mem_oh, pipe_oh;
  logic [IDW-1:0]         mem_id;
  logic                   mem_any, mem_ok, mem_adv, mem_fire;
  logic                   pipe_any, pipe_adv;

  logic                   unused_bits;
  assign unused_bits = ^{alloc_paddr_mm5[LINE_OFFSET-1:0], mem_id};

  // Allocation: merge beats allocate beats nack.
  always_comb begin
    match      = '0;
    free_oh    = '0;
    free_found = 1'b0;
    occ        = e_valid | pend_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = e_valid[i] &&
        (e_paddr[i][PA-1:LINE_OFFSET] == alloc_paddr_mm5[PA-1:LINE_OFFSET]);
      if (!occ[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
    full            = &occ;
    alloc_merge_mm5 = ~reset & alloc_req_mm5 & (|match);
    alloc_gnt_mm5   = ~reset & alloc_req_mm5 & ~(|match) & free_found;
    alloc_nack_mm5  = ~reset & alloc_req_mm5 & ~(|match) & ~free_found;
    alloc_vec_mm5   = alloc_gnt_mm5 ? free_oh : '0;
    pend_d          = alloc_vec_mm5;
  end

  // Memory request arbitration gated by credits.
  flq_rr_arb #(.N(NUM_ENTRIES), .HOLD(0)) u_mem_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (e_mem_req),
    .adv    (mem_adv),
    .win_oh (mem_oh),
    .win_id (mem_id),
    .any    (mem_any)
  );

  always_comb begin
    mem_ok    = ~reset & mem_rdy & (credits_q != '0);
    e_mem_gnt = mem_oh & {NUM_ENTRIES{mem_ok}};
    mem_adv   = mem_ok & mem_any;
    mem_fire  = |e_mem_gnt;
    credits_d = credits_q;
    if (mem_fire && !mem_rsp_valid) begin
      credits_d = credits_q - 1'b1;
    end else if (!mem_fire && mem_rsp_valid &&
                 credits_q != CW'(MEM_CREDITS)) begin
      credits_d = credits_q + 1'b1;
    end
  end

  // Pipe arbitration; winner held until granted.
  flq_rr_arb #(.N(NUM_ENTRIES), .HOLD(1)) u_pipe_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (e_pipe_req_mm0),
    .adv    (pipe_adv),
    .win_oh (pipe_oh),
    .win_id (pipe_sel_id_mm0),
    .any    (pipe_any)
  );

  always_comb begin
    pipe_req_mm0   = |e_pipe_req_mm0;
    pipe_adv       = ~reset & pipe_gnt_mm0 & pipe_any;
    e_pipe_gnt_mm0 = pipe_oh & {NUM_ENTRIES{pipe_adv}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      credits_q <= CW'(MEM_CREDITS);
    end else begin
      pend_q    <= pend_d;
      credits_q <= credits_d;
    end
  end

`ifdef FLQ_SCHED_PERF_EN
  logic [3:0][31:0] perf_q, perf_d;
  logic [3:0]       perf_inc;

  always_comb begin
    perf_inc[0] = full;
    perf_inc[1] = alloc_merge_mm5;
    perf_inc[2] = alloc_nack_mm5;
    perf_inc[3] = (|e_mem_req) & (credits_q == '0);
    for (int i = 0; i < 4; i++) begin
      perf_d[i] = perf_q[i];
      if (perf_inc[i] && perf_q[i] != '1) perf_d[i] = perf_q[i] + 32'd1;
    end
    perf_cnt = perf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end
`endif

endmodule

// File: doc/fillq_sched.md
Name: fillq_sched

Overview:
- Control block for the fill queue: owns allocation of NUM_ENTRIES fill queue entries and merges same-line misses.
- Arbitrates among entries for the single memory request port, with a credit limit on outstanding memory requests.
- Round-robin arbitrates entry requests for the MEM_FILL slot of the mem-pipe arbiter.
- Sits between the mm5 miss path, the fill queue entry array, the memory interface and the mempipe arbiter.

Parameters:
- NUM_ENTRIES, 4, number of fill queue entries (t_flq_id width = $clog2(NUM_ENTRIES)).
- MEM_CREDITS, 2, maximum outstanding memory requests (1..NUM_ENTRIES).
- LINE_OFFSET, 6, low paddr bits ignored for line match.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- alloc_req_mm5  in  1  miss requesting a fill.
- alloc_paddr_mm5  in  t_paddr  miss address.
- alloc_gnt_mm5  out  1  new entry allocated this cycle.
- alloc_vec_mm5  out  NUM_ENTRIES  one-hot entry to allocate; drives entry e_alloc_mm5.
- alloc_merge_mm5  out  1  line already pending; no allocation.
- alloc_nack_mm5  out  1  queue full, no match; requester must recycle.
- full  out  1  all entries valid.
- e_valid  in  NUM_ENTRIES  per-entry valid.
- e_paddr  in  NUM_ENTRIES x t_paddr  per-entry static paddr.
- e_mem_req  in  NUM_ENTRIES  per-entry memory request.
- e_mem_gnt  out  NUM_ENTRIES  one-hot memory grant.
- mem_rdy  in  1  memory port can accept a request.
- mem_rsp_valid  in  1  memory response returned; frees one credit.
- e_pipe_req_mm0  in  NUM_ENTRIES  per-entry pipe request.
- e_pipe_gnt_mm0  out  NUM_ENTRIES  one-hot pipe grant.
- pipe_req_mm0  out  1  fill queue requests mempipe.
- pipe_sel_id_mm0  out  t_flq_id  id of current pipe winner.
- pipe_gnt_mm0  in  1  mempipe arbiter grant to the fill queue.

Behaviour:
- Reset: mem_ptr = 0, pipe_ptr = 0, credits = MEM_CREDITS. All grant/vec outputs are 0 while reset is high. Entry state is not owned here.
- Allocation (combinational in mm5):
  - Line match = e_valid[i] & (e_paddr[i][PA-1:LINE_OFFSET] == alloc_paddr_mm5[PA-1:LINE_OFFSET]).
  - Any match -> alloc_merge_mm5 = 1, alloc_gnt_mm5 = 0.
  - Else a free entry exists -> alloc_gnt_mm5 = 1, alloc_vec_mm5 = lowest-index ~e_valid bit.
  - Else -> alloc_nack_mm5 = 1.
  - Exactly one of gnt/merge/nack is asserted when alloc_req_mm5 = 1; all three are 0 otherwise.
- Pending-alloc mask: alloc_vec_mm5 is registered one cycle and ORed into e_valid for the full and free-search logic. This covers back-to-back allocations before an entry's valid rises.
- Free in the same cycle as allocation: that entry is not reusable until the cycle after e_valid drops.
- Memory arbitration:
  - mem_win = round-robin pick of e_mem_req, starting at mem_ptr.
  - e_mem_gnt = onehot(mem_win) & mem_rdy & (credits != 0).
  - On a grant: mem_ptr <= winner + 1, wrapping modulo NUM_ENTRIES.
- Credits:
  - Grant only -> credits - 1.
  - mem_rsp_valid only -> credits + 1.
  - Both in the same cycle -> unchanged.
  - Credits never exceed MEM_CREDITS and never underflow. A response with credits == MEM_CREDITS is an error; credits saturate.
- Pipe arbitration:
  - pipe_req_mm0 = |e_pipe_req_mm0.
  - pipe_sel_id_mm0 = round-robin winner from pipe_ptr.
  - e_pipe_gnt_mm0 = onehot(winner) & pipe_gnt_mm0.
  - pipe_ptr <= winner + 1 only when pipe_gnt_mm0 = 1. While ungranted, the winner is held stable and is not re-picked.
- Latency: all grants are combinational, same cycle. Pointer and credit updates take effect the next cycle.
- Reset mid-operation: credits restore to MEM_CREDITS immediately. Responses arriving after reset are ignored (treated as saturated).

Optional Feature:
- Macro FLQ_SCHED_PERF_EN.
- When defined, 32-bit saturating counters are added: cyc_full, cnt_merge, cnt_nack, cyc_credit_stall (mem request pending with credits == 0). They are exposed as output port perf_cnt (4 x 32), and all reset to 0.
- When undefined, the port and counters are absent and functional behaviour is identical.

Decomposition:
- mem_defs package: t_flq_id, FLQ_NUM_ENTRIES, FLQ_MEM_CREDITS, FLQ_LINE_OFFSET.
- gen_funcs package: a round-robin find-first function.
- One sub-module, flq_rr_arb (request vector, pointer, advance enable -> one-hot winner plus registered pointer), instantiated twice: memory and pipe.

Test Plan:
- Empty queue, alloc_req paddr 0x1000 -> alloc_gnt = 1, alloc_vec = 0001. Next cycle alloc 0x2000 -> vec = 0010 via pending mask.
- Entry 2 valid at 0x1040, alloc 0x107C -> alloc_merge = 1, vec = 0. Alloc 0x1080 -> new allocation.
- All 4 valid, alloc to a new line -> alloc_nack = 1, full = 1. Free entry 1, next cycle alloc -> vec = 0010.
- MEM_CREDITS = 2, e_mem_req = 1111, mem_rdy = 1 -> grants to entries 0 then 1, then stall with credits = 0. mem_rsp_valid -> entry 2 granted. Simultaneous rsp and grant leaves credits unchanged.
- e_pipe_req = 0101, pipe_gnt held low 3 cycles -> pipe_sel_id stays 0. Gnt -> entry 0 granted, next winner is 2.
- Reset asserted with credits = 0 -> next cycle credits = 2, pointers = 0, all grants 0.
